vreg_port_responder: RTL and testbench

Vector register file responder for the execution unit's per-lane register request ports. It accepts `cntrl_req_t` element requests, grants them, and performs single-element reads and writes on a banked vector register store. Read data returns one cycle after the grant. It sits between the execution unit and the vector register storage, opposite the `reg_req` / `reg_req_grant` / `reg_rsp_vld` / `reg_rsp_data` initiator.

---
 rtl/vreg_port_responder_pkg.sv | 57 +++++
 rtl/vreg_port_responder_arbiter_rr.sv | 51 +++++
 rtl/vreg_port_responder.sv | 166 ++++++++++++++++
 tb/tb_vreg_port_responder.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vreg_port_responder_pkg.sv
// Shared types and constants for the vector register port responder.
//   cntrl_req_t    : per-port element request (vld/access_type/access_length/
//                    stride_type/vec_reg_ptr/addr/data)
//   v_element_t    : one vector element
//   v_register_t   : one architectural vector register (DEPTH elements)
//   access_type_e  : READ_REQ / WRITE_REQ
//   stride_type_e  : NON_STRIDE / STRIDE
//   done_state_e   : per-port element-stream tracker state
// Request fields are sized wider than the storage index so that
// out-of-range register pointers and element indices can be expressed.
package vreg_port_responder_pkg;

  localparam int VECTOR_REG_WIDTH  = 64;
  localparam int NUM_OF_VECTOR_REG = 8;
  localparam int VECTOR_REG_DEPTH  = 64;

  localparam int REG_PTR_W    = 4;
  localparam int ELEM_ADDR_W  = 8;
  localparam int ACCESS_LEN_W = 8;

  typedef enum logic {
    READ_REQ  = 1'b0,
    WRITE_REQ = 1'b1
  } access_type_e;

  typedef enum logic {
    NON_STRIDE = 1'b0,
    STRIDE     = 1'b1
  } stride_type_e;

  typedef enum logic {
    DONE_IDLE   = 1'b0,
    DONE_ACTIVE = 1'b1
  } done_state_e;

  typedef logic [VECTOR_REG_WIDTH-1:0]       v_element_t;
  typedef v_element_t [VECTOR_REG_DEPTH-1:0] v_register_t;

  typedef struct packed {
    logic                    vld;
    access_type_e            access_type;
    logic [ACCESS_LEN_W-1:0] access_length;
    stride_type_e            stride_type;
    logic [REG_PTR_W-1:0]    vec_reg_ptr;
    logic [ELEM_ADDR_W-1:0]  addr;
    v_element_t              data;
  } cntrl_req_t;

  // A zero length is treated as a single-element access.
  function automatic logic is_last_elem(input logic [ELEM_ADDR_W-1:0]  addr,
                                        input logic [ACCESS_LEN_W-1:0] len);
    logic [ACCESS_LEN_W-1:0] last_idx;
    last_idx = (len == '0) ? '0 : (len - ACCESS_LEN_W'(1));
    return (addr == last_idx);
  endfunction

endpackage

// File: rtl/vreg_port_responder_arbiter_rr.sv
// arbiter_rr: round-robin one-hot arbiter.
//   clk, reset (async, active-low)
//   req_i [VECTOR_IN] : requesting inputs
//   gnt_o [VECTOR_IN] : one-hot grant (combinational)
// The priority pointer is a one-hot register reset to input 0; after every
// grant it moves to the input just past the winner.
module arbiter_rr #(
  parameter int VECTOR_IN = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [VECTOR_IN-1:0] req_i,
  output logic [VECTOR_IN-1:0] gnt_o
);

  logic [VECTOR_IN-1:0] ptr_q, ptr_d;
  logic                 arb_seen;
  logic                 arb_found;

  // Walk twice around the ring: start granting once the pointer bit is seen.
  always_comb begin
    gnt_o     = '0;
    arb_seen  = 1'b0;
    arb_found = 1'b0;
    for (int k = 0; k < 2 * VECTOR_IN; k++) begin
      if (ptr_q[k % VECTOR_IN]) arb_seen = 1'b1;
      if (arb_seen && !arb_found && req_i[k % VECTOR_IN]) begin
        gnt_o[k % VECTOR_IN] = 1'b1;
        arb_found            = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (arb_found) begin
      for (int i = 0; i < VECTOR_IN; i++) begin
        ptr_d[(i + 1) % VECTOR_IN] = gnt_o[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= VECTOR_IN'(1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/vreg_port_responder.sv
// vreg_port_responder: per-lane vector register request responder.
//   clk, reset (async, active-low)
//   reg_req       [NUM_PORTS] in  : cntrl_req_t element requests
//   reg_req_grant [NUM_PORTS] out : request accepted this cycle (combinational)
//   reg_rsp_vld   [NUM_PORTS] out : read data valid, one cycle after grant
//   reg_rsp_data  [NUM_PORTS] out : read element
//   reg_rsp_err   [NUM_PORTS] out : out-of-range access flag, with response timing
//   reg_done      [NUM_PORTS] out : pulse one cycle after the last-element grant
// Reads are always granted; writes share a single storage write port through
// arbiter_rr. Storage is not reset.
// Build option: VREG_RAW_BYPASS_EN forwards a same-cycle winning write to a
// read of the same element; otherwise the read sees the old storage value.
//
// Done tracker states:
//   state       | meaning
//   DONE_IDLE   | no element stream in progress on this port
//   DONE_ACTIVE | stream started, last element not yet granted
module vreg_port_responder #(
  parameter int NUM_PORTS         = 2,
  parameter int NUM_OF_VECTOR_REG = vreg_port_responder_pkg::NUM_OF_VECTOR_REG,
  parameter int VECTOR_REG_DEPTH  = vreg_port_responder_pkg::VECTOR_REG_DEPTH,
  parameter int VECTOR_REG_WIDTH  = vreg_port_responder_pkg::VECTOR_REG_WIDTH
) (
  input  logic                                clk,
  input  logic                                reset,
  input  vreg_port_responder_pkg::cntrl_req_t reg_req       [NUM_PORTS],
  output logic                                reg_req_grant [NUM_PORTS],
  output logic                                reg_rsp_vld   [NUM_PORTS],
  output logic [VECTOR_REG_WIDTH-1:0]         reg_rsp_data  [NUM_PORTS],
  output logic                                reg_rsp_err   [NUM_PORTS],
  output logic                                reg_done      [NUM_PORTS]
);
  import vreg_port_responder_pkg::*;

  localparam int PTR_IDX_W  = $clog2(NUM_OF_VECTOR_REG);
  localparam int ADDR_IDX_W = $clog2(VECTOR_REG_DEPTH);
  localparam logic [REG_PTR_W-1:0]   NREG_LIM  = REG_PTR_W'(NUM_OF_VECTOR_REG);
  localparam logic [ELEM_ADDR_W-1:0] DEPTH_LIM = ELEM_ADDR_W'(VECTOR_REG_DEPTH);

  logic [VECTOR_REG_WIDTH-1:0] mem_q [NUM_OF_VECTOR_REG][VECTOR_REG_DEPTH];

  logic [NUM_PORTS-1:0] rd_req, wr_req, wr_gnt, gnt, oor, last_elem;
  logic [NUM_PORTS-1:0] stride_unused;

  logic                        wr_en;
  logic [PTR_IDX_W-1:0]        wr_ptr_idx;
  logic [ADDR_IDX_W-1:0]       wr_addr_idx;
  logic [VECTOR_REG_WIDTH-1:0] wr_data;

  logic [NUM_PORTS-1:0]        rsp_vld_q, rsp_vld_d;
  logic [NUM_PORTS-1:0]        rsp_err_q, rsp_err_d;
  logic [NUM_PORTS-1:0]        done_q, done_d;
  logic [VECTOR_REG_WIDTH-1:0] rsp_data_q [NUM_PORTS];
  logic [VECTOR_REG_WIDTH-1:0] rsp_data_d [NUM_PORTS];
  done_state_e                 done_state_q [NUM_PORTS];
  done_state_e                 done_state_d [NUM_PORTS];

  // Request decode. Gating with reset keeps grants low while reset is held.
  // STRIDE requests are served exactly like NON_STRIDE at element addr.
  always_comb begin
    rd_req        = '0;
    wr_req        = '0;
    oor           = '0;
    last_elem     = '0;
    stride_unused = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rd_req[p]        = reset && reg_req[p].vld && (reg_req[p].access_type == READ_REQ);
      wr_req[p]        = reset && reg_req[p].vld && (reg_req[p].access_type == WRITE_REQ);
      oor[p]           = (reg_req[p].addr >= DEPTH_LIM) || (reg_req[p].vec_reg_ptr >= NREG_LIM);
      last_elem[p]     = is_last_elem(reg_req[p].addr, reg_req[p].access_length);
      stride_unused[p] = reg_req[p].stride_type;
    end
  end

  arbiter_rr #(
    .VECTOR_IN (NUM_PORTS)
  ) u_wr_arb (
    .clk   (clk),
    .reset (reset),
    .req_i (wr_req),
    .gnt_o (wr_gnt)
  );

  assign gnt = rd_req | wr_gnt;

  // Winning write selection; out-of-range writes are granted but dropped.
  always_comb begin
    wr_en       = 1'b0;
    wr_ptr_idx  = '0;
    wr_addr_idx = '0;
    wr_data     = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (wr_gnt[p]) begin
        wr_en       = !oor[p];
        wr_ptr_idx  = reg_req[p].vec_reg_ptr[PTR_IDX_W-1:0];
        wr_addr_idx = reg_req[p].addr[ADDR_IDX_W-1:0];
        wr_data     = reg_req[p].data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_idx][wr_addr_idx] <= wr_data;
    end
  end

  // Response and done-tracker next state.
  always_comb begin
    rsp_vld_d = rd_req;
    rsp_err_d = gnt & oor;
    done_d    = gnt & last_elem;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rsp_data_d[p]   = rsp_data_q[p];
      done_state_d[p] = done_state_q[p];
      if (rd_req[p]) begin
        if (oor[p]) begin
          rsp_data_d[p] = '0;
        end else begin
          rsp_data_d[p] = mem_q[reg_req[p].vec_reg_ptr[PTR_IDX_W-1:0]]
                               [reg_req[p].addr[ADDR_IDX_W-1:0]];
`ifdef VREG_RAW_BYPASS_EN
          if (wr_en && (wr_ptr_idx == reg_req[p].vec_reg_ptr[PTR_IDX_W-1:0]) &&
              (wr_addr_idx == reg_req[p].addr[ADDR_IDX_W-1:0])) begin
            rsp_data_d[p] = wr_data;
          end
`endif
        end
      end
      if (gnt[p]) begin
        done_state_d[p] = last_elem[p] ? DONE_IDLE : DONE_ACTIVE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_vld_q <= '0;
      rsp_err_q <= '0;
      done_q    <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        rsp_data_q[p]   <= '0;
        done_state_q[p] <= DONE_IDLE;
      end
    end else begin
      rsp_vld_q <= rsp_vld_d;
      rsp_err_q <= rsp_err_d;
      done_q    <= done_d;
      for (int p = 0; p < NUM_PORTS; p++) begin
        rsp_data_q[p]   <= rsp_data_d[p];
        done_state_q[p] <= done_state_d[p];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      reg_req_grant[p] = gnt[p];
      reg_rsp_vld[p]   = rsp_vld_q[p];
      reg_rsp_data[p]  = rsp_data_q[p];
      reg_rsp_err[p]   = rsp_err_q[p];
      reg_done[p]      = done_q[p];
    end
  end

endmodule

// File: tb/tb_vreg_port_responder.sv
// Self-checking bench for vreg_port_responder: directed scenarios followed by
// randomized traffic, all checked against a behavioural model of the register
// store, the round-robin write pointer and the response timing.
module tb_vreg_port_responder;
  import vreg_port_responder_pkg::*;

  localparam int NP = 2;
  localparam int NR = NUM_OF_VECTOR_REG;
  localparam int ND = VECTOR_REG_DEPTH;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  cntrl_req_t  req      [NP];
  logic        gnt      [NP];
  logic        rsp_vld  [NP];
  logic [63:0] rsp_data [NP];
  logic        rsp_err  [NP];
  logic        done     [NP];

  always #5 clk = ~clk;

  vreg_port_responder #(
    .NUM_PORTS (NP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .reg_req       (req),
    .reg_req_grant (gnt),
    .reg_rsp_vld   (rsp_vld),
    .reg_rsp_data  (rsp_data),
    .reg_rsp_err   (rsp_err),
    .reg_done      (done)
  );

  int checks = 0;
  int failures = 0;

  logic [63:0] mdl_mem   [NR][ND];
  bit          mdl_known [NR][ND];
  int          rr_ptr = 0;
  bit          ex_vld [NP], ex_err [NP], ex_done [NP], ex_known [NP];
  logic [63:0] ex_data [NP];
  bit          gnt_seen [NP], hold [NP];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_range(input cntrl_req_t r);
    return (int'(r.vec_reg_ptr) < NR) && (int'(r.addr) < ND);
  endfunction

  task automatic clear_reqs();
    for (int p = 0; p < NP; p++) begin
      req[p]  = '0;
      hold[p] = 1'b0;
    end
  endtask

  task automatic set_req(input int p, input access_type_e t, input int ptr, input int addr,
                         input logic [63:0] data, input int len);
    req[p].vld           = 1'b1;
    req[p].access_type   = t;
    req[p].access_length = 8'(len);
    req[p].stride_type   = NON_STRIDE;
    req[p].vec_reg_ptr   = 4'(ptr);
    req[p].addr          = 8'(addr);
    req[p].data          = data;
  endtask

  task automatic forget_model();
    for (int p = 0; p < NP; p++) begin
      ex_vld[p] = 0; ex_err[p] = 0; ex_done[p] = 0; ex_known[p] = 0; hold[p] = 0;
    end
    rr_ptr = 0;
    for (int r = 0; r < NR; r++)
      for (int a = 0; a < ND; a++) mdl_known[r][a] = 0;
  endtask

  // One clock cycle: check last cycle's responses and this cycle's grants,
  // then advance the model as the clock edge will.
  task automatic step();
    int          win;
    int          q, len;
    bit          nv [NP], ne [NP], nd [NP], nk [NP];
    logic [63:0] ndat [NP];
    bit          exp_g;
    @(negedge clk);
    for (int p = 0; p < NP; p++) begin
      check($sformatf("rsp_vld[%0d]", p), rsp_vld[p], ex_vld[p]);
      check($sformatf("rsp_err[%0d]", p), rsp_err[p], ex_err[p]);
      check($sformatf("done[%0d]", p), done[p], ex_done[p]);
      if (ex_vld[p] && ex_known[p])
        check($sformatf("rsp_data[%0d]", p), rsp_data[p], ex_data[p]);
    end
    win = -1;
    if (reset) begin
      for (int k = 0; k < NP; k++) begin
        q = (rr_ptr + k) % NP;
        if (win < 0 && req[q].vld && req[q].access_type == WRITE_REQ) win = q;
      end
    end
    for (int p = 0; p < NP; p++) begin
      exp_g = reset && req[p].vld && (req[p].access_type == READ_REQ || p == win);
      check($sformatf("grant[%0d]", p), gnt[p], exp_g);
      gnt_seen[p] = exp_g;
      hold[p] = reset && req[p].vld && req[p].access_type == WRITE_REQ && p != win;
      nv[p] = exp_g && req[p].access_type == READ_REQ;
      ne[p] = exp_g && !in_range(req[p]);
      len   = (req[p].access_length == 0) ? 1 : int'(req[p].access_length);
      nd[p] = exp_g && (int'(req[p].addr) == len - 1);
      nk[p] = 0;
      ndat[p] = '0;
      if (nv[p]) begin
        if (!in_range(req[p])) begin
          nk[p] = 1;
        end else begin
          ndat[p] = mdl_mem[req[p].vec_reg_ptr][req[p].addr];
          nk[p]   = mdl_known[req[p].vec_reg_ptr][req[p].addr];
        end
      end
    end
    if (win >= 0 && in_range(req[win])) begin
`ifdef VREG_RAW_BYPASS_EN
      for (int p = 0; p < NP; p++) begin
        if (nv[p] && in_range(req[p]) && req[p].vec_reg_ptr == req[win].vec_reg_ptr &&
            req[p].addr == req[win].addr) begin
          ndat[p] = req[win].data;
          nk[p]   = 1;
        end
      end
`endif
      mdl_mem[req[win].vec_reg_ptr][req[win].addr]   = req[win].data;
      mdl_known[req[win].vec_reg_ptr][req[win].addr] = 1;
    end
    if (win >= 0) rr_ptr = (win + 1) % NP;
    if (!reset) rr_ptr = 0;
    for (int p = 0; p < NP; p++) begin
      ex_vld[p] = nv[p]; ex_err[p] = ne[p]; ex_done[p] = nd[p];
      ex_known[p] = nk[p]; ex_data[p] = ndat[p];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_reqs();
    for (int p = 0; p < NP; p++) begin
      if (!hold[p]) begin
        req[p].vld           = ($urandom_range(0, 3) != 0);
        req[p].access_type   = ($urandom_range(0, 1) != 0) ? WRITE_REQ : READ_REQ;
        req[p].stride_type   = ($urandom_range(0, 1) != 0) ? STRIDE : NON_STRIDE;
        req[p].vec_reg_ptr   = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(8, 15))
                                                            : 4'($urandom_range(0, 1));
        if ($urandom_range(0, 15) == 0) req[p].addr = 8'($urandom_range(64, 255));
        else if ($urandom_range(0, 1) != 0) req[p].addr = 8'($urandom_range(0, 4));
        else req[p].addr = 8'($urandom_range(0, 63));
        req[p].access_length = 8'($urandom_range(0, 4));
        req[p].data          = {$urandom, $urandom};
      end
    end
  endtask

  initial begin
    clear_reqs();
    forget_model();
    #2 reset = 1'b0;
    // Reset state, with requests present: nothing granted, outputs low.
    set_req(0, READ_REQ, 0, 0, '0, 1);
    set_req(1, WRITE_REQ, 0, 1, 64'h1, 1);
    step();
    step();
    clear_reqs();
    reset = 1'b1;

    // Fill storage so every later read has a known expected value.
    for (int r = 0; r < NR; r++) begin
      for (int a = 0; a < ND; a++) begin
        set_req(0, WRITE_REQ, r, a, (r == 4 && a == 2) ? 64'h0A : {$urandom, $urandom}, 0);
        step();
      end
    end
    clear_reqs();

    // Write v3[5] on port 0, read it back on port 1.
    set_req(0, WRITE_REQ, 3, 5, 64'hDEAD_BEEF, 1);
    step();
    clear_reqs();
    set_req(1, READ_REQ, 3, 5, '0, 1);
    step();
    check("t1_read_grant", gnt_seen[1], 1'b1);
    check("t1_rsp_vld", rsp_vld[1], 1'b1);
    check("t1_rsp_data", rsp_data[1], 64'hDEAD_BEEF);
    clear_reqs();

    // Bring the write pointer back to port 0, then collide two writes.
    set_req(1, WRITE_REQ, 7, 63, 64'h77, 1);
    step();
    clear_reqs();
    set_req(0, WRITE_REQ, 1, 0, 64'h11, 1);
    set_req(1, WRITE_REQ, 1, 1, 64'h22, 1);
    step();
    check("t2_c1_gnt0", gnt_seen[0], 1'b1);
    check("t2_c1_gnt1", gnt_seen[1], 1'b0);
    req[0] = '0;
    step();
    check("t2_c2_gnt1", gnt_seen[1], 1'b1);
    clear_reqs();
    set_req(0, READ_REQ, 1, 0, '0, 1);
    set_req(1, READ_REQ, 1, 1, '0, 1);
    step();
    check("t2_rd0", rsp_data[0], 64'h11);
    check("t2_rd1", rsp_data[1], 64'h22);
    clear_reqs();

    // Back-to-back stream v2[0..7].
    for (int a = 0; a < 8; a++) begin
      set_req(0, READ_REQ, 2, a, '0, 8);
      step();
      check($sformatf("t3_vld_%0d", a), rsp_vld[0], 1'b1);
      check($sformatf("t3_done_%0d", a), done[0], (a == 7) ? 1'b1 : 1'b0);
    end
    clear_reqs();
    step();
    check("t3_vld_after", rsp_vld[0], 1'b0);

    // Out-of-range read and writes; aliasing targets are re-read via the model.
    set_req(0, READ_REQ, 0, 64, '0, 1);
    step();
    check("t4_rd_vld", rsp_vld[0], 1'b1);
    check("t4_rd_data", rsp_data[0], 64'h0);
    check("t4_rd_err", rsp_err[0], 1'b1);
    set_req(0, WRITE_REQ, 0, 64, 64'hFFFF_FFFF, 1);
    step();
    check("t4_wr_err", rsp_err[0], 1'b1);
    check("t4_wr_vld", rsp_vld[0], 1'b0);
    set_req(0, WRITE_REQ, 8, 3, 64'hBAD0, 1);
    step();
    check("t4_wr2_err", rsp_err[0], 1'b1);
    set_req(0, READ_REQ, 0, 0, '0, 1);
    set_req(1, READ_REQ, 0, 3, '0, 1);
    step();
    clear_reqs();
    step();

    // Same-cycle write and read of v4[2].
    set_req(0, WRITE_REQ, 4, 2, 64'h55, 1);
    set_req(1, READ_REQ, 4, 2, '0, 1);
    step();
`ifdef VREG_RAW_BYPASS_EN
    check("t5_raw", rsp_data[1], 64'h55);
`else
    check("t5_raw", rsp_data[1], 64'h0A);
`endif
    clear_reqs();
    set_req(0, READ_REQ, 4, 2, '0, 1);
    step();
    check("t5_after", rsp_data[0], 64'h55);
    clear_reqs();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      randomize_reqs();
      step();
    end
    clear_reqs();
    step();

    // Reset right after a read grant of an unfinished stream.
    set_req(0, READ_REQ, 2, 0, '0, 4);
    @(negedge clk);
    check("t6_grant", gnt[0], 1'b1);
    #1 reset = 1'b0;
    #1;
    check("t6_grant_in_reset", gnt[0], 1'b0);
    forget_model();
    @(posedge clk);
    #1;
    check("t6_vld_in_reset", rsp_vld[0], 1'b0);
    step();
    step();
    clear_reqs();
    reset = 1'b1;
    step();
    set_req(0, WRITE_REQ, 0, 0, 64'hA0, 1);
    set_req(1, WRITE_REQ, 0, 1, 64'hA1, 1);
    step();
    check("t6_ptr_gnt0", gnt_seen[0], 1'b1);
    check("t6_ptr_gnt1", gnt_seen[1], 1'b0);
    req[0] = '0;
    step();
    clear_reqs();
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("t6_no_done_%0d", c), done[0], 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
